// File: rtl/rom_lookup_arb_pkg.sv
// Shared types and constants for the two-requester ROM lookup arbiter.
// Holds the FSM state encoding, default bus widths and the one-hot pulse helper.
package rom_lookup_arb_pkg;

  localparam int DEF_ROM_AW = 8;
  localparam int DEF_ROM_DW = 8;
  localparam int N_REQ      = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // One-hot pulse vector for requester idx, gated by fire.
  function automatic logic [N_REQ-1:0] grant_vec(input logic idx, input logic fire);
    grant_vec = {fire & idx, fire & ~idx};
  endfunction

endpackage

// File: rtl/rom_lookup_arb_if.sv
// Requester-side handshake bundle of the ROM lookup arbiter.
// master = requesters (testbench / clients), slave = arbiter.
interface rom_lookup_arb_if
  import rom_lookup_arb_pkg::*;
#(
  parameter int AW = DEF_ROM_AW,
  parameter int DW = DEF_ROM_DW
);
  logic          req0;
  logic          req1;
  logic [AW-1:0] add0;
  logic [AW-1:0] add1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata;
  logic          busy;

  modport master (
    output req0, req1, add0, add1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy
  );

  modport slave (
    input  req0, req1, add0, add1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, busy
  );
endinterface

// File: rtl/rom_lookup_arb_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins outright, under contention the
// requester that was not served last wins.
module rr_pick2
  import rom_lookup_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             last,
  output logic             winner
);

  // Winner selection from the request pair and the last-served pointer
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/rom_lookup_arb.sv
// Round-robin arbiter sharing one registered lookup ROM between two requesters.
// One lookup per three cycles: IDLE (accept) -> ISSUE (ROM reads) -> WAIT (capture).
module rom_lookup_arb
  import rom_lookup_arb_pkg::*;
#(
  parameter int ROM_AW = DEF_ROM_AW,
  parameter int ROM_DW = DEF_ROM_DW
) (
  input  logic              CS,
  input  logic              cen,
  rom_lookup_arb_if.slave   bus,
  output logic [ROM_AW-1:0] rom_add,
  input  logic [ROM_DW-1:0] rom_q
);

  state_t            state_r;
  state_t            state_s;
  logic              fire_s;
  logic              winner_s;
  logic              owner_r;
  logic              last_r;
  logic              busy_r;
  logic [N_REQ-1:0]  req_s;
  logic [N_REQ-1:0]  gnt_s;
  logic [N_REQ-1:0]  rvalid_s;
  logic [N_REQ-1:0]  gnt_r;
  logic [N_REQ-1:0]  rvalid_r;
  logic [ROM_AW-1:0] add_sel_s;
  logic [ROM_AW-1:0] rom_add_r;
  logic [ROM_DW-1:0] rdata_r;

  // Requests are levels held by the clients, so anything raised while busy is
  // simply still present when the FSM next sits in IDLE.
  assign req_s = {bus.req1, bus.req0};

  rr_pick2 u_pick (
    .req    (req_s),
    .last   (last_r),
    .winner (winner_s)
  );

  // Next-state logic; fire_s marks the edge at which a request is accepted
  always_comb begin
    state_s = state_r;
    fire_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|req_s) begin
          state_s = ST_ISSUE;
          fire_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Winner address mux and the one-hot pulses registered at this edge
  always_comb begin
    add_sel_s = winner_s ? bus.add1 : bus.add0;
    gnt_s     = grant_vec(winner_s, fire_s);
    rvalid_s  = grant_vec(owner_r, state_r == ST_WAIT);
  end

  // Control state: FSM, pulses, owner and last-served pointer (resets to favour req0)
  always_ff @(posedge CS) begin
    if (!cen) begin
      state_r  <= ST_IDLE;
      busy_r   <= 1'b0;
      gnt_r    <= {N_REQ{1'b0}};
      rvalid_r <= {N_REQ{1'b0}};
      owner_r  <= 1'b0;
      last_r   <= 1'b1;
    end else begin
      state_r  <= state_s;
      busy_r   <= (state_s != ST_IDLE);
      gnt_r    <= gnt_s;
      rvalid_r <= rvalid_s;
      if (fire_s) begin
        owner_r <= winner_s;
        last_r  <= winner_s;
      end
    end
  end

  // Datapath: ROM address launched on accept, ROM data captured in WAIT
  always_ff @(posedge CS) begin
    if (!cen) begin
      rom_add_r <= {ROM_AW{1'b0}};
      rdata_r   <= {ROM_DW{1'b0}};
    end else begin
      if (fire_s) begin
        rom_add_r <= add_sel_s;
      end
      if (state_r == ST_WAIT) begin
        rdata_r <= rom_q;
      end
    end
  end

  assign rom_add     = rom_add_r;
  assign bus.gnt0    = gnt_r[0];
  assign bus.gnt1    = gnt_r[1];
  assign bus.rvalid0 = rvalid_r[0];
  assign bus.rvalid1 = rvalid_r[1];
  assign bus.rdata   = rdata_r;
  assign bus.busy    = busy_r;

endmodule

// File: tb/tb_rom_lookup_arb.sv
// Self-checking bench for rom_lookup_arb: directed scenarios then random traffic,
// all compared against a timeline model of accepted lookups.
module tb_rom_lookup_arb;

  localparam int MAXC = 1500;

  logic       CS;
  logic       cen;
  logic [7:0] rom_add;
  logic [7:0] rom_q;

  rom_lookup_arb_if #(.AW(8), .DW(8)) bus ();

  rom_lookup_arb #(.ROM_AW(8), .ROM_DW(8)) dut (
    .CS      (CS),
    .cen     (cen),
    .bus     (bus),
    .rom_add (rom_add),
    .rom_q   (rom_q)
  );

  initial CS = 1'b0;
  always #5 CS = ~CS;

  // 256x8 lookup ROM with one cycle read latency
  always @(posedge CS) rom_q <= (rom_add == 8'h00) ? 8'h00 : 8'h02;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: each accepted lookup in cycle c yields gnt at c+1, rvalid/rdata at c+3,
  // busy during c+1..c+2; the arbiter can next accept in cycle c+3.
  bit         exp_g0 [0:MAXC+3];
  bit         exp_g1 [0:MAXC+3];
  bit         exp_v0 [0:MAXC+3];
  bit         exp_v1 [0:MAXC+3];
  bit         exp_b  [0:MAXC+3];
  bit         ra_set [0:MAXC+3];
  logic [7:0] ra_val [0:MAXC+3];
  logic [7:0] rd_val [0:MAXC+3];
  int         free_m    = 0;
  bit         last_m    = 1'b1;
  logic [7:0] rom_add_m = 8'h00;
  logic [7:0] rdata_m   = 8'h00;

  function automatic logic [7:0] rom_val(input logic [7:0] a);
    return (a == 8'h00) ? 8'h00 : 8'h02;
  endfunction

  function automatic logic [7:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 3);
    if (sel == 0) return 8'h00;
    if (sel == 1) return 8'hFF;
    return 8'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Model the inputs of the current cycle, advance one clock, compare every output.
  task automatic step();
    bit rst_now;
    bit w;
    logic [7:0] a;
    rst_now = 1'b0;
    if (!cen) begin
      rst_now = 1'b1;
      for (int k = cyc + 1; k <= MAXC + 3; k++) begin
        exp_g0[k] = 1'b0; exp_g1[k] = 1'b0; exp_v0[k] = 1'b0; exp_v1[k] = 1'b0;
        exp_b[k]  = 1'b0; ra_set[k] = 1'b0;
      end
      last_m = 1'b1;
      free_m = cyc + 1;
    end else if (cyc >= free_m && (bus.req0 || bus.req1)) begin
      if (bus.req0 && bus.req1) w = (last_m == 1'b0) ? 1'b1 : 1'b0;
      else                      w = bus.req1;
      a = w ? bus.add1 : bus.add0;
      if (w) begin exp_g1[cyc+1] = 1'b1; exp_v1[cyc+3] = 1'b1; end
      else   begin exp_g0[cyc+1] = 1'b1; exp_v0[cyc+3] = 1'b1; end
      exp_b[cyc+1]  = 1'b1;
      exp_b[cyc+2]  = 1'b1;
      ra_set[cyc+1] = 1'b1;
      ra_val[cyc+1] = a;
      rd_val[cyc+3] = rom_val(a);
      last_m = w;
      free_m = cyc + 3;
    end
    @(posedge CS);
    cyc++;
    #1;
    if (rst_now) begin rom_add_m = 8'h00; rdata_m = 8'h00; end
    if (ra_set[cyc]) rom_add_m = ra_val[cyc];
    if (exp_v0[cyc] || exp_v1[cyc]) rdata_m = rd_val[cyc];
    chk("gnt0",    bus.gnt0,    exp_g0[cyc]);
    chk("gnt1",    bus.gnt1,    exp_g1[cyc]);
    chk("rvalid0", bus.rvalid0, exp_v0[cyc]);
    chk("rvalid1", bus.rvalid1, exp_v1[cyc]);
    chk("busy",    bus.busy,    exp_b[cyc]);
    chk("rom_add", rom_add,     rom_add_m);
    chk("rdata",   bus.rdata,   rdata_m);
  endtask

  // Random clients: hold a request until its grant, then drop it; rare resets.
  task automatic drive_random();
    if (bus.req0 && exp_g0[cyc]) bus.req0 = 1'b0;
    else if (!bus.req0 && $urandom_range(0, 2) == 0) begin
      bus.req0 = 1'b1;
      bus.add0 = rand_addr();
    end
    if (bus.req1 && exp_g1[cyc]) bus.req1 = 1'b0;
    else if (!bus.req1 && $urandom_range(0, 2) == 0) begin
      bus.req1 = 1'b1;
      bus.add1 = rand_addr();
    end
    cen = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
  endtask

  initial begin
    cen = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.add0 = 8'h00; bus.add1 = 8'h00;

    // Reset state
    step();
    step();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rom_add", rom_add, 8'h00);
    cen = 1'b1;
    step();

    // Single lookup, requester drops in its grant cycle
    bus.req0 = 1'b1; bus.add0 = 8'h05;
    step();
    chk("single_gnt0", bus.gnt0, 1'b1);
    chk("single_rom_add", rom_add, 8'h05);
    bus.req0 = 1'b0;
    step();
    step();
    chk("single_rvalid0", bus.rvalid0, 1'b1);
    chk("single_rdata", bus.rdata, 8'h02);
    step();

    // Zero address on requester 1
    bus.req1 = 1'b1; bus.add1 = 8'h00;
    step();
    chk("zero_gnt1", bus.gnt1, 1'b1);
    bus.req1 = 1'b0;
    step();
    step();
    chk("zero_rvalid1", bus.rvalid1, 1'b1);
    chk("zero_rvalid0", bus.rvalid0, 1'b0);
    chk("zero_rdata", bus.rdata, 8'h00);
    step();

    // Contention from reset release: gnt0, gnt1, gnt0, gnt1 at cycles 1, 4, 7, 10
    cen = 1'b0;
    bus.req0 = 1'b1; bus.add0 = 8'hFF;
    bus.req1 = 1'b1; bus.add1 = 8'h3C;
    step();
    cen = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1 || k == 7) chk("cont_gnt0", bus.gnt0, 1'b1);
      if (k == 4 || k == 10) chk("cont_gnt1", bus.gnt1, 1'b1);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (3) step();

    // Pending: req1 raised during req0's lookup
    bus.req0 = 1'b1; bus.add0 = 8'h11;
    step();
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.add1 = 8'hFF;
    step();
    step();
    step();
    chk("pend_gnt1", bus.gnt1, 1'b1);
    bus.req1 = 1'b0;
    step();
    step();
    chk("pend_rvalid1", bus.rvalid1, 1'b1);
    chk("pend_rdata", bus.rdata, 8'h02);
    step();

    // Reset mid-lookup, then both request: pointer must favour req0 again
    bus.req0 = 1'b1; bus.add0 = 8'h00;
    step();
    bus.req0 = 1'b0;
    step();
    cen = 1'b0;
    step();
    chk("midrst_rvalid0", bus.rvalid0, 1'b0);
    chk("midrst_rdata", bus.rdata, 8'h00);
    chk("midrst_busy", bus.busy, 1'b0);
    cen = 1'b1;
    bus.req0 = 1'b1; bus.add0 = 8'h80;
    bus.req1 = 1'b1; bus.add1 = 8'h81;
    step();
    chk("midrst_gnt0", bus.gnt0, 1'b1);
    bus.req0 = 1'b0;
    repeat (3) step();
    chk("midrst_gnt1", bus.gnt1, 1'b1);
    bus.req1 = 1'b0;
    repeat (3) step();

    // Early drop: rvalid0 still arrives and no second gnt0
    bus.req0 = 1'b1; bus.add0 = 8'h7E;
    step();
    bus.req0 = 1'b0;
    step();
    step();
    chk("drop_rvalid0", bus.rvalid0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drop_no_gnt0", bus.gnt0, 1'b0);
    end

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      drive_random();
      step();
    end
    cen = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
